// File: rtl/frac_clk_sched.sv
// Dual-modulus fractional clock scheduler: NUM_A periods of DIV_A cycles, then NUM_B of DIV_B.
// New ratios are buffered in a one-deep pending slot and only take effect at frame boundaries.
module frac_clk_sched #(
    parameter int DIV_W     = 8,
    parameter int CNT_W     = 8,
    parameter int DEF_DIV_A = 5,
    parameter int DEF_NUM_A = 9,
    parameter int DEF_DIV_B = 8,
    parameter int DEF_NUM_B = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div_a,
    input  logic [CNT_W-1:0] cfg_num_a,
    input  logic [DIV_W-1:0] cfg_div_b,
    input  logic [CNT_W-1:0] cfg_num_b,
    output logic             clk_out,
    output logic             frame_done,
    output logic             phase_b,
    output logic             active
);

    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B} state_t;

    state_t           state, next_state, restart_state;
    logic [DIV_W-1:0] div_a, div_b, pend_div_a, pend_div_b, period_cnt, cur_div;
    logic [CNT_W-1:0] num_a, num_b, pend_num_a, pend_num_b, phase_cnt, cur_num;
    logic [CNT_W-1:0] new_num_a, new_num_b;
    logic             pend_full, accept, load_pend;
    logic             period_end, phase_end, frame_end;
    logic             clk_out_nxt, frame_done_nxt, phase_b_nxt, active_nxt;

    function automatic logic [DIV_W-1:0] fix_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    assign cfg_ready = ~pend_full;
    assign accept    = cfg_valid & ~pend_full;

    always_comb begin
        cur_div    = (state == RUN_B) ? div_b : div_a;
        cur_num    = (state == RUN_B) ? num_b : num_a;
        period_end = (state != IDLE) && (period_cnt == cur_div - DIV_W'(1));
        phase_end  = period_end && (phase_cnt == cur_num - CNT_W'(1));
        frame_end  = phase_end && ((state == RUN_B) || (num_b == '0));
        // Only a config already pending before this edge is applied; one accepted now waits.
        load_pend  = pend_full && ((state == IDLE) || frame_end);
        new_num_a  = load_pend ? pend_num_a : num_a;
        new_num_b  = load_pend ? pend_num_b : num_b;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pend_full  <= 1'b0;
            pend_div_a <= '0;
            pend_num_a <= '0;
            pend_div_b <= '0;
            pend_num_b <= '0;
            div_a      <= DIV_W'(DEF_DIV_A);
            num_a      <= CNT_W'(DEF_NUM_A);
            div_b      <= DIV_W'(DEF_DIV_B);
            num_b      <= CNT_W'(DEF_NUM_B);
        end else begin
            if (accept) begin
                pend_full  <= 1'b1;
                pend_div_a <= fix_div(cfg_div_a);
                pend_num_a <= cfg_num_a;
                pend_div_b <= fix_div(cfg_div_b);
                pend_num_b <= cfg_num_b;
            end else if (load_pend) begin
                pend_full  <= 1'b0;
            end
            if (load_pend) begin
                div_a <= pend_div_a;
                num_a <= pend_num_a;
                div_b <= pend_div_b;
                num_b <= pend_num_b;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            phase_cnt  <= '0;
            clk_out    <= 1'b0;
            frame_done <= 1'b0;
            phase_b    <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= next_state;
            clk_out    <= clk_out_nxt;
            frame_done <= frame_done_nxt;
            phase_b    <= phase_b_nxt;
            active     <= active_nxt;
            if (state == IDLE || period_end) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + DIV_W'(1);
            end
            if (state == IDLE || phase_end) begin
                phase_cnt <= '0;
            end else if (period_end) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        restart_state = IDLE;
        if (en && ((new_num_a != '0) || (new_num_b != '0))) begin
            restart_state = (new_num_a != '0) ? RUN_A : RUN_B;
        end
        next_state = state;
        case (state)
            IDLE: begin
                if (!pend_full && en && ((num_a != '0) || (num_b != '0))) begin
                    next_state = (num_a != '0) ? RUN_A : RUN_B;
                end
            end
            RUN_A: begin
                if (phase_end) begin
                    next_state = (num_b != '0) ? RUN_B : restart_state;
                end
            end
            RUN_B: begin
                if (phase_end) begin
                    next_state = restart_state;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clk_out_nxt    = period_end;
        frame_done_nxt = frame_end;
        phase_b_nxt    = (next_state == RUN_B);
        active_nxt     = (next_state != IDLE);
    end

endmodule

// File: tb/tb_frac_clk_sched.sv
// Directed bench for frac_clk_sched: expected pulses are queued by the stimulus
// and consumed by an independent monitor on the falling edge.
module tb_frac_clk_sched;

    logic       clk_in = 1'b0;
    logic       rst, en, cfg_valid, cfg_ready;
    logic [7:0] cfg_div_a, cfg_div_b;
    logic [7:0] cfg_num_a, cfg_num_b;
    logic       clk_out, frame_done, phase_b, active;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        logic fd;
    } pulse_t;
    pulse_t exp_q[$];

    frac_clk_sched dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div_a (cfg_div_a),
        .cfg_num_a (cfg_num_a),
        .cfg_div_b (cfg_div_b),
        .cfg_num_b (cfg_num_b),
        .clk_out   (clk_out),
        .frame_done(frame_done),
        .phase_b   (phase_b),
        .active    (active)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input int da, input int na, input int db, input int nb);
        cfg_valid = v;
        cfg_div_a = 8'(da);
        cfg_num_a = 8'(na);
        cfg_div_b = 8'(db);
        cfg_num_b = 8'(nb);
    endtask

    task automatic pushPulse(input int c, input logic fd);
        pulse_t p;
        p.cyc = c;
        p.fd  = fd;
        exp_q.push_back(p);
    endtask

    // Hand model of one frame with sanitised divisors; returns the next frame's start edge.
    task automatic pushFrame(input int base, input int da, input int na, input int db,
                             input int nb, output int nxt);
        int t = base;
        for (int i = 0; i < na; i++) begin
            t += da;
            pushPulse(t, (nb == 0) && (i == na - 1));
        end
        for (int i = 0; i < nb; i++) begin
            t += db;
            pushPulse(t, i == nb - 1);
        end
        nxt = t;
    endtask

    task automatic waitCyc(input int target);
        if (cyc > target) begin
            checkOutput("schedule_order", cyc, target);
        end
        while (cyc < target) @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checkOutput("missed_pulse", 0, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (clk_out || frame_done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", cyc, -1);
                end else begin
                    pulse_t p;
                    p = exp_q.pop_front();
                    checkOutput("pulse_cycle", cyc, p.cyc);
                    checkOutput("pulse_clk_out", int'(clk_out), 1);
                    checkOutput("pulse_frame_done", int'(frame_done), int'(p.fd));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, r, r2, r3;
        rst = 1'b1;
        en  = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_in);
        checkOutput("rst_clk_out", int'(clk_out), 0);
        checkOutput("rst_frame_done", int'(frame_done), 0);
        checkOutput("rst_phase_b", int'(phase_b), 0);
        checkOutput("rst_active", int'(active), 0);
        checkOutput("rst_cfg_ready", int'(cfg_ready), 1);

        // Defaults 53/10, then mid-frame (3,2,4,1), pure /4, sanitised /2, defaults again.
        rst = 1'b0;
        en  = 1'b1;
        b1  = cyc + 1;
        pushFrame(b1, 5, 9, 8, 1, b2);
        pushFrame(b2, 5, 9, 8, 1, b3);
        pushFrame(b3, 3, 2, 4, 1, b4);
        pushFrame(b4, 3, 2, 4, 1, b5);
        pushFrame(b5, 2, 0, 4, 1, b6);
        pushFrame(b6, 2, 0, 4, 1, b7);
        pushFrame(b7, 2, 0, 4, 1, b8);
        pushFrame(b8, 2, 3, 2, 0, b9);
        pushFrame(b9, 2, 3, 2, 0, b10);
        pushFrame(b10, 5, 9, 8, 1, b11);

        waitCyc(b1 + 1);
        checkOutput("t1_active", int'(active), 1);
        checkOutput("t1_phase_a", int'(phase_b), 0);
        waitCyc(b1 + 48);
        checkOutput("t1_phase_b", int'(phase_b), 1);

        waitCyc(b2 + 19);
        applyStimulus(1'b1, 3, 2, 4, 1);
        waitCyc(b2 + 20);
        applyStimulus(1'b0, 0, 0, 0, 0);
        checkOutput("t2_ready_low", int'(cfg_ready), 0);
        waitCyc(b2 + 52);
        checkOutput("t2_ready_held", int'(cfg_ready), 0);
        waitCyc(b2 + 53);
        checkOutput("t2_ready_free", int'(cfg_ready), 1);

        waitCyc(b4 + 1);
        applyStimulus(1'b1, 9, 0, 4, 1);
        waitCyc(b4 + 2);
        applyStimulus(1'b0, 0, 0, 0, 0);
        waitCyc(b5 + 1);
        checkOutput("t3_phase_b_0", int'(phase_b), 1);
        waitCyc(b6 + 2);
        checkOutput("t3_phase_b_1", int'(phase_b), 1);

        // Accepted on the boundary edge itself: must wait one more /4 frame.
        waitCyc(b7 - 1);
        applyStimulus(1'b1, 1, 3, 0, 0);
        waitCyc(b7);
        applyStimulus(1'b0, 0, 0, 0, 0);
        checkOutput("t4_ready_low", int'(cfg_ready), 0);
        checkOutput("t4_phase_b_2", int'(phase_b), 1);
        waitCyc(b7 + 3);
        checkOutput("t4_phase_b_3", int'(phase_b), 1);
        waitCyc(b8 + 1);
        checkOutput("t4_ready_free", int'(cfg_ready), 1);
        checkOutput("t4_phase_a", int'(phase_b), 0);

        waitCyc(b9);
        applyStimulus(1'b1, 5, 9, 8, 1);
        waitCyc(b9 + 1);
        applyStimulus(1'b0, 0, 0, 0, 0);
        waitCyc(b10 + 29);
        en = 1'b0;
        waitCyc(b10 + 52);
        checkOutput("t5_active_run", int'(active), 1);
        waitCyc(b10 + 53);
        checkOutput("t5_active_idle", int'(active), 0);
        waitCyc(b11 + 15);
        checkOutput("t5_idle_active", int'(active), 0);
        checkOutput("t5_idle_clk_out", int'(clk_out), 0);

        en = 1'b1;
        r  = cyc + 1;
        pushPulse(r + 5, 1'b0);
        pushPulse(r + 10, 1'b0);
        waitCyc(r + 10);
        applyStimulus(1'b1, 3, 2, 4, 1);
        waitCyc(r + 11);
        applyStimulus(1'b0, 0, 0, 0, 0);
        checkOutput("t6_ready_low", int'(cfg_ready), 0);
        waitCyc(r + 12);
        checkOutput("t6_active_pre", int'(active), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_clk_out", int'(clk_out), 0);
        checkOutput("t6_rst_frame_done", int'(frame_done), 0);
        checkOutput("t6_rst_phase_b", int'(phase_b), 0);
        checkOutput("t6_rst_active", int'(active), 0);
        checkOutput("t6_rst_cfg_ready", int'(cfg_ready), 1);
        waitCyc(r + 14);
        rst = 1'b0;
        r2  = cyc + 1;
        pushFrame(r2, 5, 9, 8, 1, r3);
        waitCyc(r2 + 10);
        en = 1'b0;
        waitCyc(r3 + 10);
        checkOutput("t6_final_active", int'(active), 0);
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
